// File: rtl/branch_flush_ctrl_pkg.sv
// Pipeline-wide definitions for control-flow resolution: opcode encodings,
// squash-controller state encoding and the control-flow opcode decode.
package branch_flush_ctrl_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_BEQ = 4'b1000;
  localparam opcode_t OP_JAL = 4'b1001;
  localparam opcode_t OP_JLR = 4'b1010;
  localparam opcode_t OP_JRI = 4'b1011;
  localparam opcode_t OP_BNE = 4'b1100;
  localparam opcode_t OP_BLT = 4'b1101;

  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic logic is_ctrl_flow(input opcode_t op);
    case (op)
      OP_BEQ, OP_JAL, OP_JLR, OP_JRI, OP_BNE, OP_BLT: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_flush_ctrl_cond_eval.sv
// Purely combinational branch-condition evaluator: opcode plus operands to
// take. Shared between the decode-stage squash logic and execute-stage resolver.
module branch_cond_eval
  import branch_flush_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  opcode_t           opcode,
  input  logic [DATA_W-1:0] read_data0,
  input  logic [DATA_W-1:0] read_data1,
  output logic              take
);

  // NOTE: a default assignment ahead of the case keeps every path driven, so
  // no latch can be inferred if the decode list grows.
  always_comb begin
    take = 1'b0;
    case (opcode)
      OP_BEQ:                 take = (read_data0 == read_data1);
      OP_BNE:                 take = (read_data0 != read_data1);
      OP_BLT:                 take = ($signed(read_data0) < $signed(read_data1));
      OP_JAL, OP_JLR, OP_JRI: take = 1'b1;
      default:                take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flush_ctrl.sv
// Decode-stage branch squash controller: same-cycle IF/ID squash, redirect
// handshake with the PC unit, programmable flush bubbles and saturating stats.
module branch_flush_ctrl
  import branch_flush_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned OPC_W     = 4,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              valid_out_IFID,
  input  logic [DATA_W-1:0] read_data0,
  input  logic [DATA_W-1:0] read_data1,
  input  logic              stall_in,
  input  logic              redirect_ready,
  output logic              valid_in,
  output logic              redirect_req,
  output logic              flush_busy,
  output logic [CNT_W-1:0]  resolved_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYC);

  state_e                 state_q;
  logic                   redirect_req_q;
  logic                   flush_busy_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0]       resolved_q, resolved_d;
  logic [CNT_W-1:0]       taken_q, taken_d;

  logic opc_hi_zero;
  logic is_ctrl;
  logic take;
  logic accept;
  logic squash;

  // Opcodes wider than the 4-bit encoding must not alias onto a branch.
  if (OPC_W > 4) begin : g_wide_opc
    assign opc_hi_zero = ~|opcode[OPC_W-1:4];
  end else begin : g_narrow_opc
    assign opc_hi_zero = 1'b1;
  end

  assign is_ctrl = opc_hi_zero && is_ctrl_flow(opcode[3:0]);

  branch_cond_eval #(
    .DATA_W(DATA_W)
  ) u_cond_eval (
    .opcode    (opcode[3:0]),
    .read_data0(read_data0),
    .read_data1(read_data1),
    .take      (take)
  );

  assign accept = (state_q == ST_IDLE) && valid_out_IFID && !stall_in && is_ctrl;
  assign squash = accept && take;

  // IF/ID stays valid under reset regardless of what sits in decode.
  assign valid_in = !rst_n || ((state_q == ST_IDLE) && !squash);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and ordering between blocks is moot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      redirect_req_q <= 1'b0;
      flush_busy_q   <= 1'b0;
      flush_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (squash) begin
            state_q        <= ST_REQ;
            redirect_req_q <= 1'b1;
            flush_busy_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (redirect_ready) begin
            redirect_req_q <= 1'b0;
            if (FLUSH_CYC != 0) begin
              state_q     <= ST_FLUSH;
              flush_cnt_q <= FLUSH_LOAD;
            end else begin
              state_q      <= ST_IDLE;
              flush_busy_q <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          // Counter runs through stalls; the last bubble is the cycle it reads 1.
          if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
            state_q      <= ST_IDLE;
            flush_busy_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - FLUSH_CNT_W'(1);
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          redirect_req_q <= 1'b0;
          flush_busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign resolved_d = (accept && (resolved_q != '1)) ? resolved_q + CNT_W'(1) : resolved_q;
  assign taken_d    = (squash && (taken_q != '1))    ? taken_q + CNT_W'(1)    : taken_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_q <= '0;
      taken_q    <= '0;
    end else begin
      resolved_q <= resolved_d;
      taken_q    <= taken_d;
    end
  end

  assign redirect_req = redirect_req_q;
  assign flush_busy   = flush_busy_q;
  assign resolved_cnt = resolved_q;
  assign taken_cnt    = taken_q;

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Directed bench for branch_flush_ctrl: vector table on the default build plus
// hand-written sequences on FLUSH_CYC=3 and FLUSH_CYC=0/CNT_W=2 builds.
module tb_branch_flush_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  opcode;
  logic        valid_out_IFID;
  logic [15:0] read_data0;
  logic [15:0] read_data1;
  logic        stall_in;
  logic        redirect_ready;

  logic        vin_a, req_a, busy_a;
  logic [15:0] res_a, tak_a;
  logic        vin_b, req_b, busy_b;
  logic [15:0] res_b, tak_b;
  logic        vin_c, req_c, busy_c;
  logic [1:0]  res_c, tak_c;

  int n_pass  = 0;
  int n_total = 0;

  branch_flush_ctrl #(.FLUSH_CYC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .valid_out_IFID(valid_out_IFID),
    .read_data0(read_data0), .read_data1(read_data1), .stall_in(stall_in),
    .redirect_ready(redirect_ready), .valid_in(vin_a), .redirect_req(req_a),
    .flush_busy(busy_a), .resolved_cnt(res_a), .taken_cnt(tak_a)
  );

  branch_flush_ctrl #(.FLUSH_CYC(3)) u_dut_f3 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .valid_out_IFID(valid_out_IFID),
    .read_data0(read_data0), .read_data1(read_data1), .stall_in(stall_in),
    .redirect_ready(redirect_ready), .valid_in(vin_b), .redirect_req(req_b),
    .flush_busy(busy_b), .resolved_cnt(res_b), .taken_cnt(tak_b)
  );

  branch_flush_ctrl #(.FLUSH_CYC(0), .CNT_W(2)) u_dut_f0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .valid_out_IFID(valid_out_IFID),
    .read_data0(read_data0), .read_data1(read_data1), .stall_in(stall_in),
    .redirect_ready(redirect_ready), .valid_in(vin_c), .redirect_req(req_c),
    .flush_busy(busy_c), .resolved_cnt(res_c), .taken_cnt(tak_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  opc;
    logic [15:0] a;
    logic [15:0] b;
    logic        vld;
    logic        stl;
    logic        exp_acc;
    logic        exp_take;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                       input logic vld, input logic stl);
    opcode         = opc;
    read_data0     = a;
    read_data1     = b;
    valid_out_IFID = vld;
    stall_in       = stl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    redirect_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_res;
    int exp_tak;

    //            opc     a         b         vld   stl   acc   take
    vecs[0]  = '{4'b1000, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1}; // BEQ equal
    vecs[1]  = '{4'b1100, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b0}; // BNE equal
    vecs[2]  = '{4'b1101, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1}; // BLT -1 < 1
    vecs[3]  = '{4'b1000, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0}; // BEQ unequal
    vecs[4]  = '{4'b1101, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0}; // BLT 1 < -1
    vecs[5]  = '{4'b1101, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b1}; // BLT min < max
    vecs[6]  = '{4'b1010, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1}; // JLR
    vecs[7]  = '{4'b1011, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b1}; // JRI
    vecs[8]  = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}; // non-branch
    vecs[9]  = '{4'b1110, 16'h0003, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0}; // unused opcode
    vecs[10] = '{4'b1000, 16'h0007, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0}; // BEQ not valid
    vecs[11] = '{4'b1001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}; // JAL stalled
    vecs[12] = '{4'b1100, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1}; // BNE unequal
    vecs[13] = '{4'b1000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1}; // BEQ zeros

    // Reset state, with a taken branch sitting in decode.
    rst_n = 1'b0;
    redirect_ready = 1'b0;
    drive(4'b1001, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    check("reset valid_in", 32'(vin_a), 32'd1);
    check("reset redirect_req", 32'(req_a), 32'd0);
    check("reset flush_busy", 32'(busy_a), 32'd0);
    check("reset resolved_cnt", 32'(res_a), 32'd0);
    check("reset taken_cnt", 32'(tak_a), 32'd0);
    do_reset();

    exp_res = 0;
    exp_tak = 0;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].vld, vecs[i].stl);
      #1;
      check($sformatf("vec%0d valid_in", i), 32'(vin_a),
            32'(!(vecs[i].exp_acc && vecs[i].exp_take)));
      tick();
      drive(4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      exp_res += int'(vecs[i].exp_acc);
      exp_tak += int'(vecs[i].exp_acc && vecs[i].exp_take);
      check($sformatf("vec%0d redirect_req", i), 32'(req_a), 32'(vecs[i].exp_take));
      check($sformatf("vec%0d resolved_cnt", i), 32'(res_a), 32'(exp_res));
      check($sformatf("vec%0d taken_cnt", i), 32'(tak_a), 32'(exp_tak));
      if (req_a) begin
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check($sformatf("vec%0d flush valid_in", i), 32'(vin_a), 32'd0);
        check($sformatf("vec%0d flush req low", i), 32'(req_a), 32'd0);
        tick();
        check($sformatf("vec%0d back idle", i), 32'(busy_a), 32'd0);
        check($sformatf("vec%0d idle valid_in", i), 32'(vin_a), 32'd1);
      end
    end

    // FLUSH_CYC=3: ready delayed two cycles, JRI in decode during FLUSH.
    do_reset();
    drive(4'b1001, 16'h0, 16'h0, 1'b1, 1'b0);
    #1;
    check("f3 squash", 32'(vin_b), 32'd0);
    tick();
    drive(4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("f3 req c1", 32'(req_b), 32'd1);
    check("f3 valid_in c1", 32'(vin_b), 32'd0);
    tick();
    check("f3 req c2", 32'(req_b), 32'd1);
    tick();
    check("f3 req c3", 32'(req_b), 32'd1);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    drive(4'b1011, 16'h0, 16'h0, 1'b1, 1'b0);
    check("f3 flush1 req", 32'(req_b), 32'd0);
    check("f3 flush1 busy", 32'(busy_b), 32'd1);
    check("f3 flush1 valid_in", 32'(vin_b), 32'd0);
    tick();
    check("f3 flush2 valid_in", 32'(vin_b), 32'd0);
    tick();
    drive(4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("f3 flush3 busy", 32'(busy_b), 32'd1);
    check("f3 flush3 valid_in", 32'(vin_b), 32'd0);
    tick();
    check("f3 idle busy", 32'(busy_b), 32'd0);
    check("f3 idle valid_in", 32'(vin_b), 32'd1);
    check("f3 resolved (JRI ignored)", 32'(res_b), 32'd1);
    check("f3 taken (JRI ignored)", 32'(tak_b), 32'd1);

    // Stalled JAL: no squash or request until the stall drops.
    do_reset();
    drive(4'b1001, 16'h0, 16'h0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("stall%0d valid_in", k), 32'(vin_a), 32'd1);
      check($sformatf("stall%0d req", k), 32'(req_a), 32'd0);
      tick();
    end
    check("stall resolved", 32'(res_a), 32'd0);
    stall_in = 1'b0;
    #1;
    check("unstall squash", 32'(vin_a), 32'd0);
    tick();
    drive(4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("unstall req", 32'(req_a), 32'd1);
    check("unstall resolved", 32'(res_a), 32'd1);

    // FLUSH_CYC=0: REQ returns straight to IDLE.
    do_reset();
    drive(4'b1001, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    drive(4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("f0 req", 32'(req_c), 32'd1);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check("f0 idle busy", 32'(busy_c), 32'd0);
    check("f0 idle req", 32'(req_c), 32'd0);
    check("f0 idle valid_in", 32'(vin_c), 32'd1);

    // CNT_W=2 saturation over five taken JALs.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b1001, 16'h0, 16'h0, 1'b1, 1'b0);
      tick();
      drive(4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      if (k == 2) check("sat taken after 3", 32'(tak_c), 32'd3);
    end
    check("sat taken after 5", 32'(tak_c), 32'd3);
    check("sat resolved after 5", 32'(res_c), 32'd3);

    // Reset mid-REQ drops the redirect at once.
    do_reset();
    drive(4'b1001, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    check("midreq req", 32'(req_c), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreq reset req", 32'(req_c), 32'd0);
    check("midreq reset busy", 32'(busy_c), 32'd0);
    check("midreq reset valid_in", 32'(vin_c), 32'd1);
    check("midreq reset taken", 32'(tak_c), 32'd0);
    drive(4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post reset req", 32'(req_c), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_flush_ctrl.md
Name: branch_flush_ctrl

Overview:
- Parametrised successor to the IF/ID branch-squash logic of the 16-bit pipeline.
- Resolves BEQ/BNE/BLT/JAL/JLR/JRI in the decode stage and squashes the IF/ID register by driving valid_in low.
- Holds a redirect handshake with the PC unit, then inserts a programmable number of flush bubbles.
- Keeps saturating counters of resolved and taken control-flow instructions for performance debug.

Parameters:
- DATA_W, 16, width of register-file read operands.
- OPC_W, 4, opcode width.
- FLUSH_CYC, 1, bubble cycles after redirect acceptance; legal range 0..15.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OPC_W  opcode of the instruction currently in decode.
- valid_out_IFID  in  1  decode-stage instruction is valid.
- read_data0  in  DATA_W  operand A from the register file.
- read_data1  in  DATA_W  operand B from the register file.
- stall_in  in  1  pipeline hold; no branch is accepted while high.
- redirect_ready  in  1  PC unit accepts the redirect this cycle.
- valid_in  out  1  1 = IF/ID contents valid; 0 = squash.
- redirect_req  out  1  request to the PC unit to load the branch target.
- flush_busy  out  1  high in REQ or FLUSH state.
- resolved_cnt  out  CNT_W  count of accepted control-flow instructions.
- taken_cnt  out  CNT_W  count of accepted taken instructions.

Behaviour:
- Opcode encodings:
  - BEQ = 1000, JAL = 1001, JLR = 1010, JRI = 1011, BNE = 1100, BLT = 1101.
  - BLT is a signed compare: read_data0 < read_data1.
  - All other opcodes are not control flow.
- take:
  - BEQ: equal operands. BNE: unequal operands. BLT: signed less-than.
  - JAL/JLR/JRI: always.
  - Combinational.
- accept = state==IDLE && valid_out_IFID && !stall_in && opcode is control flow.
- State machine, encoded as 2 bits:
  - IDLE: if accept && take, go to REQ. Otherwise stay.
  - REQ: redirect_req=1. On redirect_ready go to FLUSH if FLUSH_CYC>0, else IDLE. REQ lasts at least 1 cycle.
  - FLUSH: a 4-bit down-counter is loaded with FLUSH_CYC on REQ exit and decrements each cycle. Leave to IDLE when it reaches 1. FLUSH is held for exactly FLUSH_CYC cycles. stall_in does not pause the counter.
- valid_in:
  - 0 in the IDLE cycle where accept && take (same-cycle squash, combinational).
  - 0 throughout REQ and FLUSH.
  - 1 in every other case, including valid_out_IFID=0, unknown opcode, and stall_in=1. No latching; fully defined for all inputs.
- Branches present in decode during REQ/FLUSH are ignored: no counting, no new request.
- Counters:
  - resolved_cnt increments on accept.
  - taken_cnt increments on accept && take.
  - Both saturate at all-ones; no wrap.
- redirect_req and flush_busy are registered, decoded from state.
- Reset values: state IDLE, redirect_req 0, flush_busy 0, counters 0. valid_in is 1 under reset.
- Reset asserted mid-REQ or mid-FLUSH returns to IDLE immediately; the pending redirect is dropped.
- redirect_ready outside REQ is ignored.

Decomposition:
- Shared package (pipeline-wide): opcode localparams (OP_BEQ … OP_BLT), state typedef/encoding (IDLE/REQ/FLUSH), and an is_ctrl_flow opcode decode function.
- One sub-module, branch_cond_eval: purely combinational opcode/operand → take, reusable by the execute-stage resolver.
- Counters stay inline.

Test Plan:
- Reset release, then BEQ with 0x1234/0x1234, valid_out_IFID=1, stall_in=0 → valid_in=0 same cycle. Next cycle redirect_req=1, resolved_cnt=1, taken_cnt=1.
- BNE with 0x0005/0x0005 → valid_in stays 1, no redirect_req, resolved_cnt +1, taken_cnt unchanged.
- BLT with 0xFFFF (-1) vs 0x0001 → taken. Same compare as BEQ instead → not taken.
- JAL with FLUSH_CYC=3 and redirect_ready delayed 2 cycles → REQ for 3 cycles, then valid_in=0 for 3 FLUSH cycles, then IDLE. A JRI presented during FLUSH is not counted.
- JAL with stall_in=1 for 4 cycles → valid_in=1 and no request. Stall drops → squash and request in that cycle.
- With FLUSH_CYC=0 → REQ→IDLE directly. Assert rst_n=0 mid-REQ → redirect_req=0 and valid_in=1 immediately. With CNT_W=2, driving 5 taken JALs → taken_cnt saturates at 3.
